// File: rtl/jpeg_bit_packer.sv
// Packs right-aligned variable-length entropy-coder groups MSB-first into a byte stream with 0xFF/0x00 stuffing and 1-padding at end of picture.
// Define JPEG_EOI_MARKER_EN to append an unstuffed 0xFF 0xD9 marker after the final picture byte.
module jpeg_bit_packer #(
   parameter int CODE_W = 32,
   parameter int ACC_W  = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CODE_W-1:0]       in_code,
   input  logic [$clog2(CODE_W):0] in_len,
   input  logic                    in_eop,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [7:0]              out_byte,
   output logic                    out_last
);

   localparam int CNT_W = $clog2(ACC_W) + 1;
`ifdef JPEG_EOI_MARKER_EN
   localparam bit EOI_EN = 1'b1;
`else
   localparam bit EOI_EN = 1'b0;
`endif

   typedef enum logic [2:0] {RUN, STUFF, FLUSH, DONE, EOI1, EOI2} state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc, acc_s, acc_nxt, code_ext;
   logic [CNT_W-1:0]   count, cnt_s, cnt_nxt, sh;
   logic               eop_pend, out_free, accept, emit_run, eop_eff, top_ff;
   logic [7:0]         top_byte, pad_byte;

   assign in_ready = (state == RUN) && !eop_pend && (count <= CNT_W'(ACC_W - CODE_W));
   assign out_free = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign emit_run = (state == RUN) && out_free && (count >= CNT_W'(8));
   assign top_byte = acc[ACC_W-1 -: 8];
   assign top_ff   = (top_byte == 8'hFF);
   assign pad_byte = top_byte | (8'hFF >> count);
   // An eop accepted in the same cycle as an extraction must still tag that byte as last.
   assign eop_eff  = eop_pend || (accept && in_eop);

   // Shift out the emitted byte first, then append the new group right under the remaining bits.
   always_comb begin
      acc_s    = emit_run ? {acc[ACC_W-9:0], 8'h00} : acc;
      cnt_s    = emit_run ? count - CNT_W'(8) : count;
      code_ext = {{(ACC_W-CODE_W){1'b0}}, in_code} & ~({ACC_W{1'b1}} << in_len);
      sh       = CNT_W'(ACC_W) - cnt_s - CNT_W'(in_len);
      acc_nxt  = acc_s;
      cnt_nxt  = cnt_s;
      if (accept) begin
         acc_nxt = acc_s | (code_ext << sh);
         cnt_nxt = cnt_s + CNT_W'(in_len);
      end
      if (state == FLUSH && out_free) begin
         acc_nxt = '0;
         cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         acc       <= '0;
         count     <= '0;
         eop_pend  <= 1'b0;
         out_valid <= 1'b0;
         out_byte  <= 8'h00;
         out_last  <= 1'b0;
      end else begin
         acc   <= acc_nxt;
         count <= cnt_nxt;
         if (accept && in_eop)
            eop_pend <= 1'b1;
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         case (state)
            RUN: begin
               if (emit_run) begin
                  out_valid <= 1'b1;
                  out_byte  <= top_byte;
                  out_last  <= !EOI_EN && eop_eff && (cnt_nxt == '0) && !top_ff;
                  if (top_ff)
                     state <= STUFF;
               end else if (out_free && eop_pend) begin
                  if (count == '0)
                     state <= EOI_EN ? EOI1 : DONE;
                  else
                     state <= FLUSH;
               end
            end
            STUFF: if (out_free) begin
               out_valid <= 1'b1;
               out_byte  <= 8'h00;
               out_last  <= !EOI_EN && eop_pend && (count == '0);
               state     <= RUN;
            end
            FLUSH: if (out_free) begin
               out_valid <= 1'b1;
               out_byte  <= pad_byte;
               out_last  <= !EOI_EN && (pad_byte != 8'hFF);
               if (pad_byte == 8'hFF)
                  state <= STUFF;
               else
                  state <= EOI_EN ? EOI1 : DONE;
            end
            EOI1: if (out_free) begin
               out_valid <= 1'b1;
               out_byte  <= 8'hFF;
               out_last  <= 1'b0;
               state     <= EOI2;
            end
            EOI2: if (out_free) begin
               out_valid <= 1'b1;
               out_byte  <= 8'hD9;
               out_last  <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               eop_pend <= 1'b0;
               state    <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Bench for jpeg_bit_packer: bit-queue reference model, per-cycle stream compare, directed literal cases and randomized pictures.
module tb_jpeg_bit_packer;
   localparam int CODE_W = 32;
   localparam int ACC_W  = 64;
   localparam int LEN_W  = $clog2(CODE_W) + 1;
`ifdef JPEG_EOI_MARKER_EN
   localparam bit EOI = 1'b1;
`else
   localparam bit EOI = 1'b0;
`endif

   logic              clk = 1'b0, rst_n = 1'b1;
   logic              in_valid = 1'b0, in_eop = 1'b0, out_ready = 1'b1;
   logic [CODE_W-1:0] in_code = '0;
   logic [LEN_W-1:0]  in_len = '0;
   logic              in_ready, out_valid, out_last;
   logic [7:0]        out_byte;

   always #5 clk = ~clk;

   jpeg_bit_packer #(.CODE_W(CODE_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_len(in_len), .in_eop(in_eop),
      .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last)
   );

   typedef struct { logic [7:0] b; logic last; } exp_t;
   exp_t expq[$];
   bit   bitq[$];
   int   n_chk = 0, n_fail = 0, cyc = 0, hold_cycles = 0, last_acc_cyc = 0;
   bit   rand_ready = 1'b0, eop_seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      if (rst_n && in_valid && in_ready)
         assert (in_len <= LEN_W'(CODE_W)) else $error("illegal in_len %0d", in_len);

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic push_byte(input logic [7:0] b, input logic last);
      exp_t e;
      e.b = b; e.last = last;
      expq.push_back(e);
      if (b == 8'hFF) begin
         e.b = 8'h00;
         expq.push_back(e);
      end
   endtask

   // Reference: the picture is one long bit string cut into bytes, stuffed, padded and tagged.
   task automatic model_push(input logic [CODE_W-1:0] code, input int len, input bit eop);
      logic [7:0] b;
      int n;
      b = 8'h00;
      for (int i = len - 1; i >= 0; i--) bitq.push_back(code[i]);
      while (bitq.size() >= 8) begin
         for (int j = 0; j < 8; j++) b = {b[6:0], bitq.pop_front()};
         push_byte(b, 1'b0);
      end
      if (eop) begin
         n = bitq.size();
         if (n > 0) begin
            b = 8'hFF;
            for (int j = 0; j < n; j++) b[7-j] = bitq[j];
            bitq.delete();
            push_byte(b, 1'b0);
         end
         if (EOI) begin
            push_byte(8'hFF, 1'b0);
            expq.pop_back();
            push_byte(8'hD9, 1'b1);
         end else if (expq.size() > 0)
            expq[expq.size()-1].last = 1'b1;
      end
   endtask

   task automatic send(input logic [CODE_W-1:0] code, input int len, input bit eop);
      int t;
      t = 0;
      @(negedge clk);
      in_valid = 1'b1; in_code = code; in_len = LEN_W'(len); in_eop = eop;
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk(1'b0, "in_ready_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_eop = 1'b0;
      last_acc_cyc = cyc;
      model_push(code, len, eop);
      if (eop) eop_seen = 1'b1;
   endtask

   // Literal byte sequence on consecutive cycles; bytes packed MSB-first in 'bytes', flags in 'lasts'.
   task automatic exp_bytes(input int n, input logic [31:0] bytes, input logic [3:0] lasts,
                            input string nm, output int first_cyc);
      int t;
      logic [7:0] eb;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      first_cyc = cyc;
      for (int i = 0; i < n; i++) begin
         eb = bytes[31-8*i -: 8];
         chk(out_valid && out_byte == eb && out_last == lasts[3-i], nm,
             32'({out_valid, out_last, out_byte}), 32'({1'b1, lasts[3-i], eb}));
         @(negedge clk);
      end
   endtask

   task automatic drain(input string nm);
      int t;
      t = 0;
      while (expq.size() > 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk(expq.size() == 0, nm, 32'(expq.size()), 32'd0);
   endtask

   // Drives out_ready and checks every presented byte against the model.
   always @(negedge clk) begin
      if (hold_cycles > 0) begin
         out_ready = 1'b0;
         hold_cycles--;
      end else if (rand_ready)
         out_ready = ($urandom_range(0, 3) != 0);
      else
         out_ready = 1'b1;
      if (rst_n) begin
         if (out_valid) begin
            if (expq.size() == 0)
               chk(1'b0, "unexpected_byte", 32'(out_byte), 32'd0);
            else begin
               chk(out_byte == expq[0].b && out_last == expq[0].last, "stream",
                   32'({out_last, out_byte}), 32'({expq[0].last, expq[0].b}));
               if (out_ready) void'(expq.pop_front());
            end
         end
         if (eop_seen) begin
            if (out_valid && out_last) eop_seen = 1'b0;
            else chk(!in_ready, "in_ready_eop", 32'(in_ready), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a_cyc, f_cyc;
      logic [7:0] held;
      int t;
      #1 rst_n = 1'b0;
      #1;
      chk(!out_valid, "rst_out_valid", 32'(out_valid), 32'd0);
      chk(out_byte == 8'h00, "rst_out_byte", 32'(out_byte), 32'd0);
      chk(!out_last, "rst_out_last", 32'(out_last), 32'd0);
      chk(in_ready, "rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // AB, CD with one-cycle latency
      fork
         begin
            send(32'hAB, 8, 1'b0);
            a_cyc = last_acc_cyc;
            chk(!out_valid, "valid_at_accept", 32'(out_valid), 32'd0);
            send(32'hCD, 8, 1'b0);
         end
         exp_bytes(2, 32'hABCD_0000, 4'b0000, "ab_cd", f_cyc);
      join
      chk(f_cyc - a_cyc == 1, "latency", 32'(f_cyc - a_cyc), 32'd1);

      // 101 + 11111 -> BF, with garbage above in_len
      fork
         begin
            send(32'hFFFF_FFF5, 3, 1'b0);
            send(32'h0000_00FF, 5, 1'b0);
         end
         exp_bytes(1, 32'hBF00_0000, 4'b0000, "pack_bf", f_cyc);
      join

      // FF, 12 -> FF 00 12; second group still accepted back-to-back
      fork
         begin
            send(32'hFF, 8, 1'b0);
            a_cyc = last_acc_cyc;
            send(32'h12, 8, 1'b0);
            chk(last_acc_cyc - a_cyc == 1, "in_ready_stuff", 32'(last_acc_cyc - a_cyc), 32'd1);
         end
         exp_bytes(3, 32'hFF00_1200, 4'b0000, "stuff_ff", f_cyc);
      join

      // zero-length group carries no bits
      send(32'hFFFF_FFFF, 0, 1'b0);

      // 01/eop -> 7F last
      fork
         send(32'h1, 2, 1'b1);
         if (EOI) exp_bytes(3, 32'h7FFF_D900, 4'b0010, "eop_pad", f_cyc);
         else     exp_bytes(1, 32'h7F00_0000, 4'b1000, "eop_pad", f_cyc);
      join

      // 1111/eop -> FF, 00 last
      fork
         send(32'hF, 4, 1'b1);
         if (EOI) exp_bytes(4, 32'hFF00_FFD9, 4'b0001, "eop_pad_ff", f_cyc);
         else     exp_bytes(2, 32'hFF00_0000, 4'b0100, "eop_pad_ff", f_cyc);
      join
      drain("drain_directed");

      // 32-bit groups against a 10-cycle stall
      hold_cycles = 10;
      fork
         begin
            for (int g = 0; g < 6; g++) send($urandom, 32, 1'b0);
            send($urandom, $urandom_range(1, 32), 1'b1);
         end
         begin
            t = 0;
            @(negedge clk);
            while (!out_valid && t < 50) begin
               @(negedge clk);
               t++;
            end
            held = out_byte;
            repeat (5) begin
               @(negedge clk);
               chk(out_valid && out_byte == held, "hold_stable", 32'(out_byte), 32'(held));
            end
            chk(!in_ready, "in_ready_full", 32'(in_ready), 32'd0);
         end
      join
      drain("drain_hold");

      // randomized pictures with random backpressure
      rand_ready = 1'b1;
      for (int p = 0; p < 10; p++) begin
         int ng;
         ng = $urandom_range(1, 12);
         for (int g = 0; g < ng; g++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            if ($urandom_range(0, 3) == 0) send(32'hFFFF_FFFF, $urandom_range(0, 32), 1'b0);
            else                           send($urandom, $urandom_range(0, 32), 1'b0);
         end
         send($urandom, $urandom_range(1, 32), 1'b1);
      end
      drain("drain_random");
      rand_ready = 1'b0;

      // reset while bytes are pending
      hold_cycles = 30;
      send(32'hAB, 8, 1'b0);
      send(32'hCD, 8, 1'b0);
      send(32'h1234_5678, 32, 1'b0);
      chk(out_valid, "pre_reset_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk(!out_valid, "async_reset_valid", 32'(out_valid), 32'd0);
      expq.delete();
      bitq.delete();
      eop_seen = 1'b0;
      hold_cycles = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk(in_ready, "post_reset_ready", 32'(in_ready), 32'd1);
      fork
         send(32'h1, 2, 1'b1);
         if (EOI) exp_bytes(3, 32'h7FFF_D900, 4'b0010, "post_reset_pic", f_cyc);
         else     exp_bytes(1, 32'h7F00_0000, 4'b1000, "post_reset_pic", f_cyc);
      join
      drain("drain_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
